// File: rtl/uart_cmd_arbiter.sv
// uart_cmd_arbiter
//   Shares one UART command engine among NUM_REQ requesters. A round-robin winner's command is
//   latched and presented to the engine. Writes complete when the engine returns to idle. Reads
//   complete when the engine returns a data byte, which is routed back to the granted requester.
//   A read, or any command the engine never picks up, is closed with an error response after
//   TIMEOUT cycles.
//
// Optional feature: define UART_ARB_PRIO0_EN to give requester 0 strict priority. The remaining
//   requesters then share round-robin among themselves.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   req_vld/req_cmd  per-requester command valid and packed commands (i at [i*CMD_WIDTH +: ...])
//   req_rdy          one-cycle accept pulse to the granted requester
//   rsp_vld          one-cycle read-response pulse; rsp_data/rsp_err hold until the next response
//   uart_cmd_*       command handshake to the engine (uart_cmd_rdy high = engine idle)
//   uart_read_*      read-data pulse and data from the engine
//   busy             high whenever a transfer is in flight
//   grant_id         index of the current or most recent grant

module uart_cmd_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned CMD_WIDTH  = 16,
   parameter int unsigned READ_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 65535
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_vld,
   input  logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd,
   output logic [NUM_REQ-1:0]           req_rdy,
   output logic [NUM_REQ-1:0]           rsp_vld,
   output logic [READ_WIDTH-1:0]        rsp_data,
   output logic                         rsp_err,
   output logic [CMD_WIDTH-1:0]         uart_cmd_in,
   output logic                         uart_cmd_vld,
   input  logic                         uart_cmd_rdy,
   input  logic                         uart_read_rdy,
   input  logic [READ_WIDTH-1:0]        uart_read_data,
   output logic                         busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

   localparam int unsigned IdW  = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0]    CntLast = CntW'(TIMEOUT - 1);
   localparam logic [CntW-1:0]    CntMax  = '1;
   localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

   typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StResp} state_e;

   state_e                state_q, state_d;
   logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
   logic [IdW-1:0]        gid_q, gid_d;
   logic [IdW-1:0]        last_q, last_d;
   logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
   logic [NUM_REQ-1:0]    req_rdy_q, req_rdy_d;
   logic [READ_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   // Arbitration: first valid requester after last_q, wrapping modulo NUM_REQ.
   logic           win_found;
   logic [IdW-1:0] win_id;
   logic [IdW-1:0] idx;

   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      idx       = '0;
`ifdef UART_ARB_PRIO0_EN
      if (req_vld[0]) begin
         win_found = 1'b1;
      end
`endif
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = IdW'((32'(last_q) + i) % NUM_REQ);
`ifdef UART_ARB_PRIO0_EN
         if (!win_found && (idx != '0) && req_vld[idx]) begin
`else
         if (!win_found && req_vld[idx]) begin
`endif
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      gid_d      = gid_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      req_rdy_d  = '0;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

      case (state_q)
         StIdle: begin
            if (win_found && uart_cmd_rdy) begin
               state_d   = StIssue;
               cmd_d     = req_cmd[32'(win_id) * CMD_WIDTH +: CMD_WIDTH];
               gid_d     = win_id;
               last_d    = win_id;
               cnt_d     = '0;
               req_rdy_d = OneHot0 << win_id;
            end
         end
         StIssue: begin
            if (!uart_cmd_rdy) begin
               state_d = StWaitDone;
               cnt_d   = '0;
            end else if (cnt_q == CntLast) begin
               // Engine never picked the command up; close it with an error, writes included.
               state_d    = StResp;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StWaitDone: begin
            if (cmd_q[CMD_WIDTH-1]) begin
               if (uart_cmd_rdy) begin
                  state_d = StIdle;
               end
            end else if (uart_read_rdy) begin
               // Data arriving on the expiry cycle still wins.
               state_d    = StResp;
               rsp_data_d = uart_read_data;
               rsp_err_d  = 1'b0;
            end else if (cnt_q == CntLast) begin
               state_d    = StResp;
               rsp_data_d = '0;
               rsp_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cmd_q      <= '0;
         gid_q      <= '0;
         last_q     <= IdW'(NUM_REQ - 1);
         cnt_q      <= '0;
         req_rdy_q  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         gid_q      <= gid_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         req_rdy_q  <= req_rdy_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_rdy      = req_rdy_q;
   assign rsp_vld      = (state_q == StResp) ? (OneHot0 << gid_q) : '0;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign uart_cmd_in  = cmd_q;
   assign uart_cmd_vld = (state_q == StIssue);
   assign busy         = (state_q != StIdle);
   assign grant_id     = gid_q;

endmodule
